// File: rtl/acc_dmem_sched_if.sv
// Bus bundle between the MIPS core, d_mem and accelerator A, routed through acc_dmem_sched.
// master = core/memory/accelerator side, slave = the scheduler.
interface acc_dmem_sched_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              acc_start;
  logic [ADDR_W-1:0] acc_startaddr;
  logic [ADDR_W-1:0] acc_size;
  logic              acc_busy;
  logic              acc_done;
  logic              acc_valid;
  logic              acc_ready;
  logic [DATA_W-1:0] acc_rdata;
  logic [ADDR_W-1:0] acc_idx;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output acc_start, acc_startaddr, acc_size, acc_ready,
    input  acc_busy, acc_done, acc_valid, acc_rdata, acc_idx,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  acc_start, acc_startaddr, acc_size, acc_ready,
    output acc_busy, acc_done, acc_valid, acc_rdata, acc_idx,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/acc_dmem_sched.sv
// Shares the single d_mem port between the core and accelerator A's burst fetch.
// Optional macro ACC_CPU_PREEMPT_EN: core requests preempt individual burst cycles.
module acc_dmem_sched #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  acc_dmem_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_idx;

  logic w_burst;
  logic w_preempt;
  logic w_core_owns;
  logic w_valid;
  logic w_xfer;
  logic w_last;

  assign w_burst = (r_state == ST_BURST);

`ifdef ACC_CPU_PREEMPT_EN
  assign w_preempt = w_burst & bus.cpu_req;
`else
  assign w_preempt = 1'b0;
`endif

  assign w_core_owns = ~w_burst | w_preempt;
  assign w_valid     = w_burst & ~w_preempt;
  assign w_xfer      = w_valid & bus.acc_ready;
  assign w_last      = (r_idx == ADDR_W'(r_count - 1'b1));

  // Burst sequencer: launch latches base/count; idx stops at size-1 on the final transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (bus.acc_start) begin
            r_base  <= bus.acc_startaddr;
            r_count <= bus.acc_size;
            r_state <= (bus.acc_size == '0) ? ST_DONE : ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_xfer) begin
            if (w_last) r_state <= ST_DONE;
            else        r_idx   <= ADDR_W'(r_idx + 1'b1);
          end
        end
        ST_DONE: begin
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port mux; memory-side outputs are forced quiet while reset is asserted.
  assign bus.mem_addr  = !reset      ? '0
                       : w_core_owns ? bus.cpu_addr
                       :               ADDR_W'(r_base + r_idx);
  assign bus.mem_we    = reset & w_core_owns & bus.cpu_req & bus.cpu_we;
  assign bus.mem_wdata = (reset & w_core_owns) ? bus.cpu_wdata : {DATA_W{1'b0}};

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = w_burst & ~w_preempt & bus.cpu_req;

  assign bus.acc_busy  = w_burst;
  assign bus.acc_done  = (r_state == ST_DONE);
  assign bus.acc_valid = w_valid;
  assign bus.acc_rdata = w_valid ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.acc_idx   = r_idx;

endmodule

// File: tb/tb_acc_dmem_sched.sv
// Directed bench for acc_dmem_sched with a combinational-read d_mem model.
module tb_acc_dmem_sched;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic mem_load;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  logic [DATA_W-1:0] dmem [64];
  logic [DATA_W-1:0] snap [64];
  logic [ADDR_W-1:0] xa_q [$];
  logic [DATA_W-1:0] xd_q [$];

  acc_dmem_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  acc_dmem_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = dmem[bus.mem_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) dmem[i] <= DATA_W'(i * 16 + 1);
    end else if (bus.mem_we === 1'b1) begin
      dmem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Transfer log and done-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.acc_valid === 1'b1 && bus.acc_ready === 1'b1) begin
      xa_q.push_back(bus.mem_addr);
      xd_q.push_back(bus.acc_rdata);
    end
    if (bus.acc_done === 1'b1) done_cnt++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s);
    next();
    xa_q.delete();
    xd_q.delete();
    bus.acc_start     = 1'b1;
    bus.acc_startaddr = a;
    bus.acc_size      = s;
    bus.acc_ready     = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.acc_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0h exp 0", bus.acc_busy); end
    checks++; if (bus.acc_done !== 1'b0) begin failures++; $display("FAIL rst_done got %0h exp 0", bus.acc_done); end
    checks++; if (bus.acc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %0h exp 0", bus.acc_valid); end
    checks++; if (bus.acc_idx !== 6'd0) begin failures++; $display("FAIL rst_idx got %0h exp 0", bus.acc_idx); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got %0h exp 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 6'd0) begin failures++; $display("FAIL rst_mem_addr got %0h exp 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_mem_wdata got %0h exp 0", bus.mem_wdata); end
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got %0h exp 0", bus.cpu_stall); end
    next();
    next();
    mem_load    = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    reset       = 1'b1;
    next();
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] ea [3] = '{6'd4, 6'd5, 6'd6};
    logic [DATA_W-1:0] ed [3] = '{32'h41, 32'h51, 32'h61};
    launch(6'd4, 6'd3);
    #1;
    checks++; if (bus.acc_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c1 got %0h exp 0", bus.acc_busy); end
    for (int c = 0; c < 3; c++) begin
      next();
      bus.acc_start = 1'b0;
      #1;
      checks++; if (bus.acc_busy !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got %0h exp 1", c, bus.acc_busy); end
      checks++; if (bus.acc_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got %0h exp 1", c, bus.acc_valid); end
      checks++; if (bus.mem_addr !== ea[c]) begin failures++; $display("FAIL basic_addr[%0d] got %0h exp %0h", c, bus.mem_addr, ea[c]); end
      checks++; if (bus.acc_rdata !== ed[c]) begin failures++; $display("FAIL basic_rdata[%0d] got %0h exp %0h", c, bus.acc_rdata, ed[c]); end
      checks++; if (bus.acc_idx !== ADDR_W'(c)) begin failures++; $display("FAIL basic_idx[%0d] got %0h exp %0h", c, bus.acc_idx, c); end
      checks++; if (bus.acc_done !== 1'b0) begin failures++; $display("FAIL basic_early_done[%0d] got %0h exp 0", c, bus.acc_done); end
    end
    next();
    #1;
    checks++; if (bus.acc_done !== 1'b1) begin failures++; $display("FAIL basic_done_c5 got %0h exp 1", bus.acc_done); end
    checks++; if (bus.acc_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c5 got %0h exp 0", bus.acc_busy); end
    checks++; if (bus.acc_valid !== 1'b0 || bus.acc_rdata !== 32'd0) begin failures++; $display("FAIL basic_valid_c5 got %0h/%0h exp 0/0", bus.acc_valid, bus.acc_rdata); end
    checks++; if (bus.acc_idx !== 6'd2) begin failures++; $display("FAIL basic_idx_done got %0h exp 2", bus.acc_idx); end
    next();
    #1;
    checks++; if (bus.acc_done !== 1'b0 || bus.acc_idx !== 6'd0) begin failures++; $display("FAIL basic_idle got done=%0h idx=%0h exp 0/0", bus.acc_done, bus.acc_idx); end
  endtask

  task automatic test_wrap();
    logic              rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [ADDR_W-1:0] ei  [6] = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd3};
    logic [ADDR_W-1:0] ea  [6] = '{6'd62, 6'd63, 6'd63, 6'd0, 6'd1, 6'd1};
    logic [ADDR_W-1:0] qa  [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
    logic [DATA_W-1:0] qd  [4] = '{32'h3E1, 32'h3F1, 32'h001, 32'h011};
    launch(6'd62, 6'd4);
    for (int c = 0; c < 6; c++) begin
      next();
      bus.acc_start = 1'b0;
      bus.acc_ready = rdy[c];
      #1;
      checks++; if (bus.acc_idx !== ei[c] || bus.mem_addr !== ea[c]) begin failures++; $display("FAIL wrap_step[%0d] got idx=%0h addr=%0h exp %0h/%0h", c, bus.acc_idx, bus.mem_addr, ei[c], ea[c]); end
      checks++; if (bus.acc_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid[%0d] got %0h exp 1", c, bus.acc_valid); end
    end
    next();
    #1;
    checks++; if (bus.acc_done !== 1'b1) begin failures++; $display("FAIL wrap_done got %0h exp 1", bus.acc_done); end
    checks++; if (xa_q.size() != 4) begin failures++; $display("FAIL wrap_xfer_count got %0d exp 4", xa_q.size()); end
    for (int k = 0; k < 4 && k < xa_q.size(); k++) begin
      checks++; if (xa_q[k] !== qa[k] || xd_q[k] !== qd[k]) begin failures++; $display("FAIL wrap_xfer[%0d] got %0h/%0h exp %0h/%0h", k, xa_q[k], xd_q[k], qa[k], qd[k]); end
    end
    next();
  endtask

  task automatic test_size0();
    launch(6'd9, 6'd0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 6'd7;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h71 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL z_launch_read got %0h stall=%0h exp 71/0", bus.cpu_rdata, bus.cpu_stall); end
    next();
    bus.acc_start = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 6'd20;
    bus.cpu_wdata = 32'hA5A5_0014;
    #1;
    checks++; if (bus.acc_done !== 1'b1 || bus.acc_busy !== 1'b0) begin failures++; $display("FAIL z_done got done=%0h busy=%0h exp 1/0", bus.acc_done, bus.acc_busy); end
    checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd20) begin failures++; $display("FAIL z_core_wr got stall=%0h we=%0h addr=%0h exp 0/1/14", bus.cpu_stall, bus.mem_we, bus.mem_addr); end
    next();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    checks++; if (dmem[20] !== 32'hA5A5_0014) begin failures++; $display("FAIL z_mem20 got %0h exp a5a50014", dmem[20]); end
    checks++; if (bus.acc_done !== 1'b0 || bus.acc_busy !== 1'b0) begin failures++; $display("FAIL z_after got done=%0h busy=%0h exp 0/0", bus.acc_done, bus.acc_busy); end
  endtask

  task automatic test_core_stall();
    logic [ADDR_W-1:0] ea [3] = '{6'd8, 6'd9, 6'd10};
`ifdef ACC_CPU_PREEMPT_EN
    logic [DATA_W-1:0] qd [3] = '{32'h81, 32'h91, 32'hDEAD_BEEF};
`else
    logic [DATA_W-1:0] qd [3] = '{32'h81, 32'h91, 32'hA1};
`endif
    launch(6'd8, 6'd3);
    next();
    bus.acc_start = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 6'd10;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
`ifdef ACC_CPU_PREEMPT_EN
    checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10) begin failures++; $display("FAIL pre_take got stall=%0h we=%0h addr=%0h exp 0/1/a", bus.cpu_stall, bus.mem_we, bus.mem_addr); end
    checks++; if (bus.acc_valid !== 1'b0 || bus.acc_idx !== 6'd0) begin failures++; $display("FAIL pre_hold got valid=%0h idx=%0h exp 0/0", bus.acc_valid, bus.acc_idx); end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next();
      #1;
      checks++; if (bus.acc_valid !== 1'b1 || bus.mem_addr !== ea[c]) begin failures++; $display("FAIL pre_burst[%0d] got valid=%0h addr=%0h exp 1/%0h", c, bus.acc_valid, bus.mem_addr, ea[c]); end
    end
    checks++; if (dmem[10] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pre_mem10 got %0h exp deadbeef", dmem[10]); end
    next();
    #1;
    checks++; if (bus.acc_done !== 1'b1) begin failures++; $display("FAIL pre_done got %0h exp 1", bus.acc_done); end
`else
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin next(); #1; end
      checks++; if (bus.cpu_stall !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL st_stall[%0d] got stall=%0h we=%0h exp 1/0", c, bus.cpu_stall, bus.mem_we); end
      checks++; if (bus.acc_valid !== 1'b1 || bus.mem_addr !== ea[c]) begin failures++; $display("FAIL st_burst[%0d] got valid=%0h addr=%0h exp 1/%0h", c, bus.acc_valid, bus.mem_addr, ea[c]); end
    end
    next();
    #1;
    checks++; if (bus.acc_done !== 1'b1 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL st_done got done=%0h stall=%0h exp 1/0", bus.acc_done, bus.cpu_stall); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_write got we=%0h addr=%0h data=%0h exp 1/a/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    next();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    checks++; if (dmem[10] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_mem10 got %0h exp deadbeef", dmem[10]); end
`endif
    checks++; if (xd_q.size() != 3) begin failures++; $display("FAIL core_xfer_count got %0d exp 3", xd_q.size()); end
    for (int k = 0; k < 3 && k < xd_q.size(); k++) begin
      checks++; if (xd_q[k] !== qd[k]) begin failures++; $display("FAIL core_xfer_data[%0d] got %0h exp %0h", k, xd_q[k], qd[k]); end
    end
    next();
  endtask

  task automatic test_restart_ignored();
    logic [ADDR_W-1:0] qa [3] = '{6'd16, 6'd17, 6'd18};
    int d0;
    d0 = done_cnt;
    launch(6'd16, 6'd3);
    next();
    bus.acc_startaddr = 6'd40;
    bus.acc_size      = 6'd1;
    #1;
    checks++; if (bus.acc_busy !== 1'b1 || bus.mem_addr !== 6'd16) begin failures++; $display("FAIL rs_first got busy=%0h addr=%0h exp 1/10", bus.acc_busy, bus.mem_addr); end
    next();
    bus.acc_start = 1'b0;
    #1;
    checks++; if (bus.mem_addr !== 6'd17 || bus.acc_idx !== 6'd1) begin failures++; $display("FAIL rs_second got addr=%0h idx=%0h exp 11/1", bus.mem_addr, bus.acc_idx); end
    for (int c = 0; c < 5; c++) next();
    #1;
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL rs_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if (xa_q.size() != 3) begin failures++; $display("FAIL rs_xfer_count got %0d exp 3", xa_q.size()); end
    for (int k = 0; k < 3 && k < xa_q.size(); k++) begin
      checks++; if (xa_q[k] !== qa[k]) begin failures++; $display("FAIL rs_xfer_addr[%0d] got %0h exp %0h", k, xa_q[k], qa[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    bit same;
    for (int i = 0; i < 64; i++) snap[i] = dmem[i];
    d0 = done_cnt;
    launch(6'd0, 6'd6);
    for (int c = 0; c < 4; c++) begin
      next();
      bus.acc_start = 1'b0;
    end
    #1;
    checks++; if (bus.acc_idx !== 6'd3) begin failures++; $display("FAIL rm_pre_idx got %0h exp 3", bus.acc_idx); end
    reset = 1'b0;
    #1;
    checks++; if (bus.acc_busy !== 1'b0 || bus.acc_valid !== 1'b0) begin failures++; $display("FAIL rm_abort got busy=%0h valid=%0h exp 0/0", bus.acc_busy, bus.acc_valid); end
    checks++; if (bus.acc_idx !== 6'd0 || bus.mem_addr !== 6'd0) begin failures++; $display("FAIL rm_clear got idx=%0h addr=%0h exp 0/0", bus.acc_idx, bus.mem_addr); end
    next();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) next();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL rm_no_done got %0d exp %0d", done_cnt, d0); end
    same = 1'b1;
    for (int i = 0; i < 64; i++) if (dmem[i] !== snap[i]) same = 1'b0;
    checks++; if (!same) begin failures++; $display("FAIL rm_mem_unchanged got changed exp unchanged"); end
  endtask

  initial begin
    reset             = 1'b0;
    mem_load          = 1'b1;
    bus.cpu_req       = 1'b1;
    bus.cpu_we        = 1'b1;
    bus.cpu_addr      = 6'd5;
    bus.cpu_wdata     = 32'h1234;
    bus.acc_start     = 1'b0;
    bus.acc_startaddr = 6'd0;
    bus.acc_size      = 6'd0;
    bus.acc_ready     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_size0();
    test_core_stall();
    test_restart_ignored();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_dmem_sched.md
Name: acc_dmem_sched

Overview:
- Sequences accelerator A's data fetch and shares the single data-memory port (d_mem) between the pipelined MIPS core and accelerator A.
- On a launch from the core, the block streams a burst of words from d_mem to the accelerator, starting at a given word address, for a given count.
- While the burst runs, core memory accesses stall. When the burst completes, the block reports completion back to the core.
- Sits between mipspipelined, d_mem and the accelerator, and replaces direct core-to-memory wiring.

Parameters:
- ADDR_W, 6, word-address width of d_mem; also the width of the burst start address and size.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  core requests a data-memory access this cycle.
- cpu_we  input  1  core access is a write; qualified by cpu_req.
- cpu_addr  input  ADDR_W  core word address.
- cpu_wdata  input  DATA_W  core write data.
- cpu_rdata  output  DATA_W  core read data; equals mem_rdata.
- cpu_stall  output  1  core must hold its access and retry.
- acc_start  input  1  core launch strobe for accelerator A.
- acc_startaddr  input  ADDR_W  first word address of the burst.
- acc_size  input  ADDR_W  number of words in the burst (0..2^ADDR_W-1).
- acc_busy  output  1  burst in progress.
- acc_done  output  1  one-cycle completion pulse.
- acc_valid  output  1  acc_rdata holds a burst word.
- acc_ready  input  1  accelerator accepts a word.
- acc_rdata  output  DATA_W  burst word to the accelerator.
- acc_idx  output  ADDR_W  index of the current burst word.
- mem_we  output  1  d_mem write enable.
- mem_addr  output  ADDR_W  d_mem address.
- mem_wdata  output  DATA_W  d_mem write data.
- mem_rdata  input  DATA_W  d_mem read data; combinational (same-cycle) read.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; internal base address and count registers cleared to 0. Outputs during reset: acc_busy=0, acc_done=0, acc_valid=0, acc_idx=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0.
- Reset mid-burst: the burst is abandoned and no acc_done is produced.
- States:
  - IDLE -> BURST on acc_start=1 with acc_size!=0. The block latches acc_startaddr as the base and acc_size as the count, and sets idx=0.
  - IDLE -> DONE on acc_start=1 with acc_size=0.
  - BURST -> DONE at the edge where the last word transfers (valid&ready with idx=size-1).
  - DONE -> IDLE unconditionally after one cycle.
- acc_start is ignored outside IDLE: no queueing and no error.
- IDLE and DONE: the core owns the port. mem_addr=cpu_addr, mem_we=cpu_req&cpu_we, mem_wdata=cpu_wdata, cpu_stall=0. If cpu_req and acc_start coincide in IDLE, the core access completes that cycle and the launch is also latched.
- BURST (accelerator owns the port):
  - mem_addr=(base+idx) mod 2^ADDR_W; the address wraps, e.g. base 62, size 4 -> 62,63,0,1.
  - mem_we=0; the accelerator is read-only.
  - acc_valid=1 and acc_rdata=mem_rdata. acc_valid must not depend combinationally on acc_ready.
  - A transfer occurs at the edge where acc_valid&acc_ready; idx increments by 1 on each transfer.
  - With acc_ready=0, idx, mem_addr and acc_valid all hold.
  - cpu_stall=cpu_req for every BURST cycle.
- acc_busy=1 exactly in BURST.
- acc_done=1 exactly in DONE, i.e. the cycle after the last transfer, or the cycle after a size-0 launch.
- acc_idx=idx; it holds its last value in DONE and returns to 0 in IDLE.
- Outside BURST: acc_valid=0 and acc_rdata=0.
- cpu_rdata=mem_rdata at all times.

Optional Feature:
- Macro: ACC_CPU_PREEMPT_EN.
- Defined: in BURST, cpu_req=1 takes the port for that cycle.
  - mem_addr, mem_we and mem_wdata come from the core, and cpu_stall=0.
  - acc_valid=0 for that cycle, so no transfer occurs and idx holds.
  - The burst resumes the next cycle the core does not request.
  - acc_done timing extends by the number of preempted cycles.
- Undefined: core requests always stall in BURST, as in Behaviour.

Test Plan:
- Reset low mid-burst (idx=3) -> on the next check: acc_busy=0, acc_valid=0, no acc_done pulse ever; d_mem contents unchanged.
- d_mem[i]=i*16+1; acc_start, startaddr=4, size=3, acc_ready=1 -> acc_valid for 3 cycles with mem_addr 4,5,6 and acc_rdata 0x41,0x51,0x61; acc_done in cycle 5 after launch; acc_busy high cycles 2-4.
- startaddr=62, size=4, acc_ready toggling 1,0,1,1,0,1 -> addresses 62,63,0,1 delivered in order; idx holds while acc_ready=0; exactly 4 transfers, then acc_done.
- acc_size=0 -> acc_busy never high; acc_done pulses the cycle after acc_start; a core write in that cycle lands with cpu_stall=0.
- Core write addr 10 data 0xDEADBEEF issued during a burst:
  - Macro undefined -> cpu_stall=1 until DONE, write lands in DONE, burst data unaffected.
  - Macro defined -> write lands the same cycle, burst stretches by 1 cycle.
- acc_start pulsed again while busy -> ignored: the original burst count and base are unchanged and only one acc_done is produced.
